fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_pc_reg.sv | 25 ++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, opcode field
// position, the default halt opcode and the fetch state enumeration.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetchState_e;

    function automatic logic [OPC_W-1:0] opcodeOf(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, load has priority over increment.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] loadValue,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= loadValue;
        end else if (inc) begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for decode until accepted, and stops after a halt opcode is accepted.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0]  RESET_PC    = 16'h0000,
    parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [OPC_W-1:0]   opcode_out,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic [15:0]        issue_count
);

    fetchState_e state;
    fetchState_e stateNext;
    logic [PC_W-1:0] pc;
    logic capture;
    logic accept;

    // A response arriving with a redirect belongs to the old path and is dropped.
    assign capture = (state == FETCH) && imem_ack && !redirect;
    assign accept  = (state == ISSUE) && instr_ready;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) uPcReg (
        .clk      (clk),
        .reset    (reset),
        .load     (redirect),
        .loadValue(redirect_pc),
        .inc      (capture),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            FETCH: if (imem_ack) stateNext = ISSUE;
            ISSUE: begin
                if (instr_ready) begin
                    stateNext = (opcodeOf(instr_out) == HALT_OPCODE) ? HALT : FETCH;
                end
            end
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
        // Redirect wins over acceptance, so a halt accepted alongside it never halts.
        if (redirect) begin
            stateNext = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_out   <= '0;
            instr_pc    <= '0;
            issue_count <= '0;
        end else begin
            if (capture) begin
                instr_out <= imem_rdata;
                instr_pc  <= pc;
            end
            if (accept) begin
                issue_count <= issue_count + 16'd1;
            end
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);
    assign opcode_out  = opcodeOf(instr_out);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected issued instructions
// into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_fetch_unit;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] cntBefore;
    } issueEntry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [3:0]  opcode_out;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [15:0] issue_count;

    int checks   = 0;
    int failures = 0;
    issueEntry_t sb[$];
    logic [15:0] expCnt = 16'h0000;

    fetch_unit #(
        .RESET_PC   (16'h0000),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out  (instr_out),
        .opcode_out (opcode_out),
        .instr_pc   (instr_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got accept of %h expected none", instr_out);
            end else begin
                issueEntry_t e;
                e = sb.pop_front();
                chk("sb_instr", instr_out, e.instr);
                chk("sb_opcode", {12'h000, opcode_out}, {12'h000, e.instr[15:12]});
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_count", issue_count, e.cntBefore);
            end
        end
    end

    // From FETCH: return rdata at once, hold in ISSUE for holdCycles with
    // garbage acks on the bus, then accept.
    task automatic issueOne(input logic [15:0] rdata, input logic [15:0] addr, input int holdCycles);
        chk("fetch_req", {15'h0, imem_req}, 16'h0001);
        chk("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        instr_ready = 1'b0;
        sb.push_back('{instr: rdata, pc: addr, cntBefore: expCnt});
        tick();
        imem_rdata = 16'hDEAD;
        for (int i = 0; i < holdCycles; i++) begin
            chk("hold_valid", {15'h0, instr_valid}, 16'h0001);
            chk("hold_instr", instr_out, rdata);
            chk("hold_pc", instr_pc, addr);
            chk("hold_count", issue_count, expCnt);
            tick();
        end
        imem_ack    = 1'b0;
        chk("issue_valid", {15'h0, instr_valid}, 16'h0001);
        chk("issue_req", {15'h0, imem_req}, 16'h0000);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        expCnt = expCnt + 16'd1;
        chk("count_after", issue_count, expCnt);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        chk("rst_valid", {15'h0, instr_valid}, 16'h0000);
        chk("rst_halted", {15'h0, halted}, 16'h0000);
        chk("rst_count", issue_count, 16'h0000);
        chk("rst_instr", instr_out, 16'h0000);
        chk("rst_ipc", instr_pc, 16'h0000);
        reset = 1'b0;
        tick();
        chk("rst_req", {15'h0, imem_req}, 16'h0001);
        chk("rst_addr", imem_addr, 16'h0000);

        // Back-to-back immediate acks
        issueOne(16'h1234, 16'h0000, 0);
        issueOne(16'h2345, 16'h0001, 0);
        chk("two_count", issue_count, 16'h0002);

        // Stalled decode for 5 cycles
        issueOne(16'h3456, 16'h0002, 5);
        chk("stall_count", issue_count, 16'h0003);

        // Redirect during an acked fetch discards the word
        redirect = 1'b1; redirect_pc = 16'h0040; imem_ack = 1'b1; imem_rdata = 16'h5555;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("redir_valid", {15'h0, instr_valid}, 16'h0000);
        chk("redir_req", {15'h0, imem_req}, 16'h0001);
        chk("redir_addr", imem_addr, 16'h0040);
        chk("redir_instr", instr_out, 16'h3456);
        issueOne(16'h6789, 16'h0040, 0);

        // Halt opcode stops fetching until redirected
        issueOne(16'hF000, 16'h0041, 0);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("halt_flag", {15'h0, halted}, 16'h0001);
            chk("halt_req", {15'h0, imem_req}, 16'h0000);
            chk("halt_valid", {15'h0, instr_valid}, 16'h0000);
            tick();
        end
        imem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        chk("unhalt_flag", {15'h0, halted}, 16'h0000);
        chk("unhalt_addr", imem_addr, 16'h0010);
        chk("unhalt_req", {15'h0, imem_req}, 16'h0001);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        issueOne(16'h7001, 16'hFFFF, 0);
        chk("wrap_addr", imem_addr, 16'h0000);

        // Halt accepted together with redirect: counted, but no halt
        imem_ack = 1'b1; imem_rdata = 16'hF123;
        sb.push_back('{instr: 16'hF123, pc: 16'h0000, cntBefore: expCnt});
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        instr_ready = 1'b0; redirect = 1'b0;
        expCnt = expCnt + 16'd1;
        chk("rhalt_count", issue_count, expCnt);
        chk("rhalt_flag", {15'h0, halted}, 16'h0000);
        chk("rhalt_req", {15'h0, imem_req}, 16'h0001);
        chk("rhalt_addr", imem_addr, 16'h0020);

        // Reset while an instruction is held
        imem_ack = 1'b1; imem_rdata = 16'h8888;
        tick();
        imem_ack = 1'b0;
        chk("pre_rst_valid", {15'h0, instr_valid}, 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", {15'h0, instr_valid}, 16'h0000);
        chk("mid_rst_addr", imem_addr, 16'h0000);
        chk("mid_rst_count", issue_count, 16'h0000);
        chk("mid_rst_instr", instr_out, 16'h0000);

        tick();
        chk("sb_empty", 16'(sb.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
